// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational reads, two prioritised writes, r0 hardwired zero,
// and a per-register busy scoreboard. Define REG_FILE_BYPASS_EN for write-through forwarding.
module reg_file_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NRD    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NRD*ADDR_W-1:0] rd_addr_i,
  output logic [NRD*DATA_W-1:0] rd_data_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_W-1:0]     wa0_i,
  input  logic [ADDR_W-1:0]     wa1_i,
  input  logic [DATA_W-1:0]     wd0_i,
  input  logic [DATA_W-1:0]     wd1_i,
  input  logic                  clr0_i,
  input  logic                  clr1_i,
  input  logic                  set_en_i,
  input  logic [ADDR_W-1:0]     set_addr_i,
  output logic [ADDR_W:0]       busy_cnt_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [Depth-1:0][DATA_W-1:0] mem_q;
  logic [Depth-1:0]             busy_q, busy_d;
  logic [ADDR_W:0]              busy_cnt_q, busy_cnt_d;

  // Port 1 is applied last so it wins on an address collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
    end else begin
      if (we0_i && (wa0_i != '0)) mem_q[wa0_i] <= wd0_i;
      if (we1_i && (wa1_i != '0)) mem_q[wa1_i] <= wd1_i;
    end
  end

  // Clears first, then set, so a same-cycle new producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (we0_i && clr0_i) busy_d[wa0_i] = 1'b0;
    if (we1_i && clr1_i) busy_d[wa1_i] = 1'b0;
    if (set_en_i && (set_addr_i != '0)) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    busy_cnt_d = '0;
    for (int r = 0; r < Depth; r++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              addr_nz;
    logic [DATA_W-1:0] stored;
    assign addr    = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign addr_nz = (addr != '0);
    assign stored  = addr_nz ? mem_q[addr] : '0;
`ifdef REG_FILE_BYPASS_EN
    logic hit0, hit1, clr_hit;
    assign hit0    = rst_ni && addr_nz && we0_i && (wa0_i == addr);
    assign hit1    = rst_ni && addr_nz && we1_i && (wa1_i == addr);
    assign clr_hit = (hit0 && clr0_i) || (hit1 && clr1_i);
    assign rd_data_o[k*DATA_W +: DATA_W] = hit1 ? wd1_i : (hit0 ? wd0_i : stored);
    assign rd_busy_o[k] = addr_nz && busy_q[addr] && !clr_hit;
`else
    assign rd_data_o[k*DATA_W +: DATA_W] = stored;
    assign rd_busy_o[k] = addr_nz && busy_q[addr];
`endif
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised self-checking bench for reg_file_mp against a behavioural array model.
module tb_reg_file_mp;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b1;
  logic [NR*AW-1:0]   rd_addr = '0;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_busy;
  logic               we0 = 0, we1 = 0, clr0 = 0, clr1 = 0, set_en = 0;
  logic [AW-1:0]      wa0 = '0, wa1 = '0, set_addr = '0;
  logic [DW-1:0]      wd0 = '0, wd1 = '0;
  logic [AW:0]        busy_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .rd_busy_o(rd_busy), .we0_i(we0), .we1_i(we1), .wa0_i(wa0), .wa1_i(wa1),
    .wd0_i(wd0), .wd1_i(wd1), .clr0_i(clr0), .clr1_i(clr1), .set_en_i(set_en),
    .set_addr_i(set_addr), .busy_cnt_o(busy_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  function automatic int m_cnt();
    int c = 0;
    for (int r = 0; r < DEPTH; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if ((we0 && clr0 && wa0 == a) || (we1 && clr1 && wa1 == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  // Applies one clock edge's worth of the architectural rules to the model.
  function automatic void model_edge();
    bit nb [DEPTH];
    for (int r = 0; r < DEPTH; r++) begin
      bit s = set_en && (set_addr == r) && (r != 0);
      bit c = (we0 && clr0 && wa0 == r) || (we1 && clr1 && wa1 == r);
      nb[r] = s ? 1'b1 : (c ? 1'b0 : m_busy[r]);
    end
    for (int r = 0; r < DEPTH; r++) m_busy[r] = nb[r];
    if (we0 && wa0 != 0) m_mem[wa0] = wd0;
    if (we1 && wa1 != 0) m_mem[wa1] = wd1;
  endfunction

  task automatic check_reads(input string tag);
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a = rd_addr[k*AW +: AW];
      check($sformatf("%s rd_data[%0d] a=%0d", tag, k, a), rd_data[k*DW +: DW], exp_rd(a));
      check($sformatf("%s rd_busy[%0d] a=%0d", tag, k, a), DW'(rd_busy[k]), DW'(exp_busy(a)));
    end
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; clr0 = 0; clr1 = 0; set_en = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; set_addr = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Called just after a negedge with inputs driven; returns just after the next negedge.
  task automatic cycle(input string tag);
    #2;
    check_reads({tag, " pre"});
    @(posedge clk_i);
    model_edge();
    #1;
    check({tag, " busy_cnt"}, DW'(busy_cnt), DW'(m_cnt()));
    check_reads({tag, " post"});
    @(negedge clk_i);
  endtask

  initial begin
    model_reset();
    #1 rst_ni = 1'b0;
    set_rd(5'd3, 5'd7);
    #2;
    check("reset rd0", rd_data[0 +: DW], '0);
    check("reset rd1", rd_data[DW +: DW], '0);
    check("reset busy", DW'(rd_busy), '0);
    check("reset cnt", DW'(busy_cnt), '0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Write to r0 is discarded.
    we0 = 1; wa0 = 5'd0; wd0 = 32'hDEADBEEF; set_rd(5'd0, 5'd0);
    cycle("r0");
    idle();
    #1 check("r0 read", rd_data[0 +: DW], '0);

    // Port 1 wins on same-address write.
    we0 = 1; wa0 = 5'd5; wd0 = 32'h11111111;
    we1 = 1; wa1 = 5'd5; wd1 = 32'h22222222; set_rd(5'd5, 5'd1);
    cycle("prio");
    idle();
    #1 check("prio r5", rd_data[0 +: DW], 32'h22222222);

    // Write-then-read timing on r7.
    we0 = 1; wa0 = 5'd7; wd0 = 32'hA5A5A5A5; set_rd(5'd7, 5'd7);
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("wr7 same cycle", rd_data[0 +: DW], 32'hA5A5A5A5);
`else
    check("wr7 same cycle", rd_data[0 +: DW], 32'h0);
`endif
    cycle("wr7");
    idle();
    #1 check("wr7 after", rd_data[DW +: DW], 32'hA5A5A5A5);

    // Scoreboard set on 3, 4, 9 then clear 3.
    set_rd(5'd3, 5'd4);
    set_en = 1; set_addr = 5'd3; cycle("set3");
    set_addr = 5'd4; cycle("set4");
    set_addr = 5'd9; cycle("set9");
    idle();
    #1;
    check("sb cnt3", DW'(busy_cnt), 32'd3);
    check("sb busy3", DW'(rd_busy[0]), 32'd1);
    we0 = 1; wa0 = 5'd3; clr0 = 1; wd0 = 32'h33;
    cycle("clr3");
    idle();
    #1;
    check("sb cnt2", DW'(busy_cnt), 32'd2);
    check("sb busy3 low", DW'(rd_busy[0]), 32'd0);

    // Set and clear of r6 in the same cycle: stays busy, holds wd1.
    set_rd(5'd6, 5'd9);
    set_en = 1; set_addr = 5'd6; cycle("set6");
    set_addr = 5'd6; we1 = 1; wa1 = 5'd6; clr1 = 1; wd1 = 32'h66666666;
    cycle("coll6");
    idle();
    #1;
    check("coll6 busy", DW'(rd_busy[0]), 32'd1);
    check("coll6 cnt", DW'(busy_cnt), 32'd3);
    check("coll6 data", rd_data[0 +: DW], 32'h66666666);
    @(negedge clk_i);

    // Randomised traffic, addresses biased low to force collisions.
    for (int i = 0; i < 400; i++) begin
      we0 = 1'($urandom); we1 = 1'($urandom); clr0 = 1'($urandom); clr1 = 1'($urandom);
      set_en = 1'($urandom);
      wa0 = ($urandom & 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wa1 = ($urandom & 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      set_addr = ($urandom & 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wd0 = $urandom; wd1 = $urandom;
      set_rd(($urandom & 1) ? AW'($urandom_range(0, 7)) : AW'($urandom), AW'($urandom));
      cycle("rnd");
    end

    // Mid-operation reset with 10 busy registers.
    idle();
    for (int r = 10; r < 20; r++) begin
      set_en = 1; set_addr = AW'(r); we0 = 1; wa0 = AW'(r); wd0 = 32'hC0DE0000 + r;
      cycle("fill");
    end
    idle();
    #1 check("fill cnt", DW'(busy_cnt), DW'(m_cnt()));
    set_rd(5'd12, 5'd15);
    we0 = 1; wa0 = 5'd12; wd0 = 32'hBADBAD00;
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    check("midrst rd0", rd_data[0 +: DW], '0);
    check("midrst rd1", rd_data[DW +: DW], '0);
    check("midrst busy", DW'(rd_busy), '0);
    check("midrst cnt", DW'(busy_cnt), '0);
    @(posedge clk_i);
    @(negedge clk_i);
    idle();
    rst_ni = 1'b1;
    #1;
    check("midrst r12", rd_data[0 +: DW], '0);
    check("midrst cnt after", DW'(busy_cnt), '0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the pipelined datapath. It provides NRD combinational read ports and two write ports with fixed priority, and treats register 0 as hardwired zero. It adds a per-register busy scoreboard that issue logic sets and writeback clears, so hazard logic can stall on pending producers. It sits between the decode stage (reads, scoreboard set) and the writeback stage (writes, scoreboard clear).

## Interface
- DATA_W, 32, bits per register
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- clk  input  1  clock; all state updates on posedge
- rstn  input  1  asynchronous, active-low reset
- rd_addr  input  NRD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  output  NRD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
- rd_busy  output  NRD  scoreboard bit of each read address
- we0, we1  input  1 each  write enables; port 1 has priority
- wa0, wa1  input  ADDR_W each  write addresses
- wd0, wd1  input  DATA_W each  write data
- clr0, clr1  input  1 each  clear the busy bit of wa0/wa1 (qualified by the matching we)
- set_en  input  1  mark set_addr busy (instruction issued)
- set_addr  input  ADDR_W  register to mark busy
- busy_cnt  output  ADDR_W+1  number of busy registers

## Operation
- Storage: 2**ADDR_W x DATA_W array plus a 2**ADDR_W busy vector.
- Reset (rstn low, asynchronous): every register 0, every busy bit 0, busy_cnt 0; rd_data reads 0; held while rstn low; all writes and sets ignored.
- Read: rd_data[k] = 0 when rd_addr[k]==0, else array[rd_addr[k]]; combinational, no clock.
- rd_busy[k] = busy[rd_addr[k]]; always 0 for address 0.
- Write: on posedge, if weN and waN!=0, array[waN] <= wdN. If both ports write the same nonzero address, wd1 is stored.
- Writes to address 0 are discarded; address 0 never becomes busy.
- Scoreboard per register r at posedge:
  - set: set_en and set_addr==r, r!=0
  - clear: (we0 and clr0 and wa0==r) or (we1 and clr1 and wa1==r)
  - set and clear on the same r in the same cycle: busy stays 1 (new producer wins).
  - set on an already-busy r: stays 1. Clear on an idle r: stays 0.
- busy_cnt: registered population count of the busy vector, updated on the same edge as the vector and always consistent with it.
- Register 0 slot is never written.

## Timing
- Read latency 0 cycles (combinational from rd_addr and stored state).
- Write latency 1 edge: data written at edge t is visible on rd_data after edge t (without bypass).
- Scoreboard latency 1 edge: set/clear at edge t is visible on rd_busy and busy_cnt after edge t.
- Reset assertion mid-cycle clears state immediately, without waiting for a clock edge. The first write is accepted at the first posedge with rstn high.

## Configuration
- REG_FILE_BYPASS_EN defined: write-through forwarding.
  - rd_data[k] returns wd1 if we1 and wa1==rd_addr[k]!=0.
  - Otherwise it returns wd0 if we0 and wa0==rd_addr[k]!=0.
  - Otherwise it returns the stored value.
  - rd_busy[k] reads 0 when the same cycle has a matching clearing write (clr asserted). This also applies when set_en targets that address in the same cycle; the next cycle then shows busy.
- Not defined: no forwarding. rd_data and rd_busy reflect stored state only; same-cycle writes become visible after the edge.

## Test plan
- Reset and zero register: pulse rstn low between edges → all rd_data 0, rd_busy 0, busy_cnt 0 with no clock. Then we0=1, wa0=0, wd0=0xDEADBEEF → reading address 0 returns 0.
- Write priority: we0=we1=1, wa0=wa1=5, wd0=0x11111111, wd1=0x22222222 → after the edge, reading address 5 returns 0x22222222.
- Write-then-read timing: write 0xA5A5A5A5 to reg 7 and read 7 in the same cycle.
  - Without bypass: old value (0) before the edge, 0xA5A5A5A5 after.
  - With REG_FILE_BYPASS_EN: 0xA5A5A5A5 in the same cycle.
- Scoreboard: set_en on regs 3, 4, 9 in three cycles → busy_cnt 3, rd_busy high when reading 3. Then we0=1, wa0=3, clr0=1 → busy_cnt 2, rd_busy for reg 3 low.
- Set/clear collision: set_en with set_addr=6 while we1=1, wa1=6, clr1=1 → reg 6 still busy, busy_cnt unchanged, reg 6 holds wd1.
- Reset mid-operation: with 10 regs busy and data written, assert rstn low between edges → busy_cnt 0 and all reads 0 immediately. A write presented during reset is not stored.
